scemi_pipe_rx_unpacker: RTL and testbench
=========================================

Name: scemi_pipe_rx_unpacker

Overview:
- HDL-side consumer stage directly downstream of an input pipe's receive operation.
- Each receive yields a payload of up to PAYLOAD_MAX_ELEMENTS elements, plus num_elements_valid and eom. This block registers that payload.
- It then streams the payload out one element per beat on a valid/ready interface to the transactor/DUT, carrying the eom marker onto the last element.
- It also counts completed messages and flags malformed payloads.

Parameters:
- BYTES_PER_ELEMENT, 1, element width in bytes; EW = BYTES_PER_ELEMENT*8.
- PAYLOAD_MAX_ELEMENTS, 4, maximum elements per accepted payload; PAYLOAD_MAX_BITS = PAYLOAD_MAX_ELEMENTS*EW.
- CNTW, $clog2(PAYLOAD_MAX_ELEMENTS+1), width of the element-count fields.
- MSGW, 16, width of the message counter.

Ports:
- clk  input  1  sole clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  payload offered.
- in_ready  output  1  block can accept the payload this cycle.
- in_data  input  PAYLOAD_MAX_BITS  payload; element i is at [i*EW +: EW], so element 0 is at the LSB.
- in_num_elements  input  CNTW  number of valid elements in in_data.
- in_eom  input  1  the payload ends a message.
- out_valid  output  1  element beat available.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  EW  current element.
- out_last  output  1  beat is the final beat of a message.
- out_empty  output  1  beat carries no data (zero-length end-of-message marker).
- msg_count  output  MSGW  number of messages completed downstream; wraps.
- err_overflow  output  1  sticky: a payload had in_num_elements > PAYLOAD_MAX_ELEMENTS.

Behaviour:
- Reset (async assert, synchronous deassert taken from rst_n edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, out_empty=0, msg_count=0, err_overflow=0.
  - Holding register, element index and count all clear.
- Reset mid-operation: any partially streamed payload is discarded. No beat is emitted for it after reset releases.
- Handshakes:
  - Accept occurs when in_valid and in_ready are both high.
  - Beat transfer occurs when out_valid and out_ready are both high.
  - out_valid, out_data, out_last and out_empty are registered. While out_valid=1 and out_ready=0 they hold stable.
- Clamping: a count n above PAYLOAD_MAX_ELEMENTS is clamped to PAYLOAD_MAX_ELEMENTS and sets err_overflow. err_overflow stays set until reset.
- States:
  - IDLE (out_valid=0, in_ready=1). On accept:
    - n=0 and in_eom=0: payload discarded, stay IDLE, no beat.
    - n=0 and in_eom=1: next cycle emit a single beat with out_empty=1, out_last=1, out_data=0. Go to UNPACK with count 1.
    - n>0: latch payload, count=n, index=0, eom. Next cycle out_valid=1 with element 0. Latency from accept to first beat is 1 cycle.
  - UNPACK: on each beat transfer, index increments and out_data takes element index+1.
    - out_last = latched eom AND (index == count-1).
    - When the final beat transfers: msg_count increments if out_last was 1, then exit per the in_ready rule.
- in_ready: in_ready = (state==IDLE) OR (state==UNPACK AND out_valid AND out_ready AND index==count-1).
  - A payload accepted in that cycle is treated exactly as an IDLE accept, so out_valid stays 1 with no bubble. Back-to-back full throughput is 1 element/cycle.
  - Otherwise the state returns to IDLE and out_valid drops.
- A payload with eom=0 produces beats that all have out_last=0. The message continues into the next payload.
- msg_count wraps from 2^MSGW-1 to 0.
- Inputs are ignored when in_ready=0. Upstream must hold its payload stable until it is accepted.

Test Plan:
- Single payload: in_data=32'hDDCCBBAA, n=4, eom=1, out_ready=1.
  - Beats AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after accept.
  - out_last only on DD; msg_count=1.
- Backpressure: same payload, out_ready toggles 1,0,0,1,…
  - Each beat holds stable while stalled; no loss or duplication.
  - in_ready=0 until the DD transfer.
- Back-to-back: two payloads {n=2, 16'h2211, eom=0} then {n=3, 24'h554433, eom=1} offered continuously.
  - Beats 11,22,33,44,55 with no bubble; out_last only on 55; msg_count=1.
- Zero-length cases:
  - n=0, eom=1: one beat with out_empty=1, out_last=1; msg_count increments.
  - n=0, eom=0: no beat, and in_ready remains 1.
- Overflow: n=7 with PAYLOAD_MAX_ELEMENTS=4.
  - Exactly 4 beats; err_overflow=1 and stays 1 across later valid payloads until reset.
- Reset mid-stream: rst_n low after 2 of 4 beats.
  - Outputs go to reset values immediately, asynchronously.
  - After release, no residual beats; msg_count=0.

Source files
------------

// File: rtl/scemi_pipe_rx_unpacker.sv
// Registers a received pipe payload and streams it out one element per beat,
// carrying eom onto the final beat, counting messages and flagging oversized counts.
module scemi_pipe_rx_unpacker #(
   parameter int unsigned BYTES_PER_ELEMENT    = 1,
   parameter int unsigned PAYLOAD_MAX_ELEMENTS = 4,
   parameter int unsigned CNTW                 = $clog2(PAYLOAD_MAX_ELEMENTS + 1),
   parameter int unsigned MSGW                 = 16,
   localparam int unsigned EW                  = BYTES_PER_ELEMENT * 8,
   localparam int unsigned PAYLOAD_MAX_BITS    = PAYLOAD_MAX_ELEMENTS * EW
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [PAYLOAD_MAX_BITS-1:0] in_data,
   input  logic [CNTW-1:0]             in_num_elements,
   input  logic                        in_eom,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [EW-1:0]               out_data,
   output logic                        out_last,
   output logic                        out_empty,
   output logic [MSGW-1:0]             msg_count,
   output logic                        err_overflow
);

   localparam logic [CNTW-1:0] MAX_N = CNTW'(PAYLOAD_MAX_ELEMENTS);

   typedef enum logic [0:0] {StIdle, StUnpack} state_t;

   state_t                      state_q, state_d;
   logic [PAYLOAD_MAX_BITS-1:0] hold_q, hold_d;
   logic [CNTW-1:0]             cnt_q, cnt_d;
   logic [CNTW-1:0]             idx_q, idx_d;
   logic                        eom_q, eom_d;
   logic                        out_valid_q, out_valid_d;
   logic [EW-1:0]               out_data_q, out_data_d;
   logic                        out_last_q, out_last_d;
   logic                        out_empty_q, out_empty_d;
   logic [MSGW-1:0]             msg_count_q, msg_count_d;
   logic                        err_q, err_d;

   logic            accept;
   logic            load;
   logic            xfer;
   logic            final_xfer;
   logic            n_over;
   logic [CNTW-1:0] n_cl;
   logic [CNTW-1:0] last_idx;
   logic [CNTW-1:0] nxt_idx;

   assign n_over   = in_num_elements > MAX_N;
   assign n_cl     = n_over ? MAX_N : in_num_elements;
   assign last_idx = cnt_q - CNTW'(1);
   assign nxt_idx  = idx_q + CNTW'(1);
   assign xfer     = out_valid_q && out_ready;
   assign final_xfer = (state_q == StUnpack) && xfer && (idx_q == last_idx);
   assign accept   = in_valid && in_ready;
   // A zero-length payload without eom carries nothing and is simply swallowed.
   assign load     = accept && ((n_cl != '0) || in_eom);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (load) state_d = StUnpack;
         StUnpack: if (final_xfer) state_d = load ? StUnpack : StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready     = (state_q == StIdle) || final_xfer;
      out_valid    = out_valid_q;
      out_data     = out_data_q;
      out_last     = out_last_q;
      out_empty    = out_empty_q;
      msg_count    = msg_count_q;
      err_overflow = err_q;
   end

   always_comb begin
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      eom_d       = eom_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_empty_d = out_empty_q;
      msg_count_d = msg_count_q;
      err_d       = err_q | (accept && n_over);

      if (final_xfer && out_last_q) begin
         msg_count_d = msg_count_q + MSGW'(1);
      end

      if (load) begin
         idx_d       = '0;
         eom_d       = in_eom;
         out_valid_d = 1'b1;
         if (n_cl == '0) begin
            // Empty end-of-message marker: one data-less beat.
            hold_d      = '0;
            cnt_d       = CNTW'(1);
            out_data_d  = '0;
            out_empty_d = 1'b1;
            out_last_d  = 1'b1;
         end else begin
            hold_d      = in_data;
            cnt_d       = n_cl;
            out_data_d  = in_data[EW-1:0];
            out_empty_d = 1'b0;
            out_last_d  = in_eom && (n_cl == CNTW'(1));
         end
      end else if (final_xfer) begin
         cnt_d       = '0;
         idx_d       = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_last_d  = 1'b0;
         out_empty_d = 1'b0;
      end else if ((state_q == StUnpack) && xfer) begin
         idx_d      = nxt_idx;
         out_data_d = hold_q[nxt_idx*EW +: EW];
         out_last_d = eom_q && (nxt_idx == last_idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         eom_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_empty_q <= 1'b0;
         msg_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         eom_q       <= eom_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_empty_q <= out_empty_d;
         msg_count_q <= msg_count_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_scemi_pipe_rx_unpacker.sv
// Directed bench for scemi_pipe_rx_unpacker: inputs driven and outputs sampled
// just after the falling edge, with hand-computed expected beats.
module tb_scemi_pipe_rx_unpacker;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [2:0]  in_num_elements;
   logic        in_eom;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_empty;
   logic [15:0] msg_count;
   logic        err_overflow;

   int checks;
   int errors;
   logic [15:0] exp_msgs;

   scemi_pipe_rx_unpacker dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_num_elements (in_num_elements),
      .in_eom          (in_eom),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_last        (out_last),
      .out_empty       (out_empty),
      .msg_count       (msg_count),
      .err_overflow    (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic offer(input logic [31:0] d, input logic [2:0] n, input logic eom);
      in_valid        = 1'b1;
      in_data         = d;
      in_num_elements = n;
      in_eom          = eom;
   endtask

   task automatic test_reset();
      #2;
      checks += 7;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
      if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
      if (out_empty !== 1'b0) begin errors++; $display("FAIL rst_out_empty got %b want 0", out_empty); end
      if (msg_count !== 16'd0) begin errors++; $display("FAIL rst_msg_count got %0d want 0", msg_count); end
      if (err_overflow !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_overflow); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] e [4];
      e[0] = 8'hAA; e[1] = 8'hBB; e[2] = 8'hCC; e[3] = 8'hDD;
      out_ready = 1'b1;
      offer(32'hDDCCBBAA, 3'd4, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         #1;
         checks += 5;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b want 1", b, out_valid); end
         if (out_data !== e[b]) begin errors++; $display("FAIL single_data[%0d] got %h want %h", b, out_data, e[b]); end
         if (out_last !== (b == 3)) begin errors++; $display("FAIL single_last[%0d] got %b want %b", b, out_last, b == 3); end
         if (out_empty !== 1'b0) begin errors++; $display("FAIL single_empty[%0d] got %b want 0", b, out_empty); end
         if (in_ready !== (b == 3)) begin errors++; $display("FAIL single_in_ready[%0d] got %b want %b", b, in_ready, b == 3); end
         @(negedge clk);
      end
      #1;
      exp_msgs++;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid got %b want 0", out_valid); end
      if (msg_count !== exp_msgs) begin errors++; $display("FAIL single_msgs got %0d want %0d", msg_count, exp_msgs); end
      if (err_overflow !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err_overflow); end
   endtask

   task automatic test_backpressure();
      logic [7:0] e [4];
      bit [3:0] pat;
      int beat;
      int cyc;
      e[0] = 8'hAA; e[1] = 8'hBB; e[2] = 8'hCC; e[3] = 8'hDD;
      pat = 4'b1001;
      beat = 0;
      cyc = 0;
      @(negedge clk);
      offer(32'hDDCCBBAA, 3'd4, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      while (beat < 4 && cyc < 40) begin
         out_ready = pat[cyc % 4];
         #1;
         checks += 4;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", cyc, out_valid); end
         if (out_data !== e[beat]) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", cyc, out_data, e[beat]); end
         if (out_last !== (beat == 3)) begin errors++; $display("FAIL bp_last[%0d] got %b want %b", cyc, out_last, beat == 3); end
         if (in_ready !== (out_ready && beat == 3)) begin
            errors++; $display("FAIL bp_in_ready[%0d] got %b want %b", cyc, in_ready, out_ready && beat == 3);
         end
         if (out_ready) beat++;
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      exp_msgs++;
      checks += 3;
      if (beat != 4) begin errors++; $display("FAIL bp_timeout beats %0d want 4", beat); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b want 0", out_valid); end
      if (msg_count !== exp_msgs) begin errors++; $display("FAIL bp_msgs got %0d want %0d", msg_count, exp_msgs); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e [5];
      bit [4:0] rdy;
      int pay;
      int beat;
      int cyc;
      logic acc;
      e[0] = 8'h11; e[1] = 8'h22; e[2] = 8'h33; e[3] = 8'h44; e[4] = 8'h55;
      rdy = 5'b10010;
      pay = 0;
      beat = 0;
      cyc = 0;
      out_ready = 1'b1;
      @(negedge clk);
      while (beat < 5 && cyc < 20) begin
         if (pay == 0) offer(32'h00002211, 3'd2, 1'b0);
         else if (pay == 1) offer(32'h00554433, 3'd3, 1'b1);
         else in_valid = 1'b0;
         #1;
         acc = in_valid && in_ready;
         if (beat > 0) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble[%0d] got %b want 1", cyc, out_valid); end
         end
         if (out_valid === 1'b1) begin
            checks += 3;
            if (out_data !== e[beat]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", beat, out_data, e[beat]); end
            if (out_last !== (beat == 4)) begin errors++; $display("FAIL b2b_last[%0d] got %b want %b", beat, out_last, beat == 4); end
            if (in_ready !== rdy[beat]) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want %b", beat, in_ready, rdy[beat]); end
            beat++;
         end
         if (acc) pay++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      exp_msgs++;
      checks += 3;
      if (beat != 5) begin errors++; $display("FAIL b2b_timeout beats %0d want 5", beat); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done_valid got %b want 0", out_valid); end
      if (msg_count !== exp_msgs) begin errors++; $display("FAIL b2b_msgs got %0d want %0d", msg_count, exp_msgs); end
   endtask

   task automatic test_zero_length();
      @(negedge clk);
      offer(32'hFFFFFFFF, 3'd0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL zeom_valid got %b want 1", out_valid); end
      if (out_empty !== 1'b1) begin errors++; $display("FAIL zeom_empty got %b want 1", out_empty); end
      if (out_last !== 1'b1) begin errors++; $display("FAIL zeom_last got %b want 1", out_last); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL zeom_data got %h want 00", out_data); end
      @(negedge clk);
      #1;
      exp_msgs++;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL zeom_done_valid got %b want 0", out_valid); end
      if (out_empty !== 1'b0) begin errors++; $display("FAIL zeom_done_empty got %b want 0", out_empty); end
      if (msg_count !== exp_msgs) begin errors++; $display("FAIL zeom_msgs got %0d want %0d", msg_count, exp_msgs); end
      // Zero elements without eom: nothing is emitted.
      @(negedge clk);
      offer(32'h12345678, 3'd0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks += 3;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL znoeom_valid[%0d] got %b want 0", c, out_valid); end
         if (in_ready !== 1'b1) begin errors++; $display("FAIL znoeom_in_ready[%0d] got %b want 1", c, in_ready); end
         if (msg_count !== exp_msgs) begin errors++; $display("FAIL znoeom_msgs[%0d] got %0d want %0d", c, msg_count, exp_msgs); end
         @(negedge clk);
      end
   endtask

   task automatic test_overflow();
      int beat;
      beat = 0;
      out_ready = 1'b1;
      offer(32'h04030201, 3'd7, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL ov_accept got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (out_valid === 1'b1) begin
            checks += 2;
            if (out_data !== 8'(beat + 1)) begin errors++; $display("FAIL ov_data[%0d] got %h want %h", beat, out_data, 8'(beat + 1)); end
            if (out_last !== (beat == 3)) begin errors++; $display("FAIL ov_last[%0d] got %b want %b", beat, out_last, beat == 3); end
            beat++;
         end
         checks++;
         if (err_overflow !== 1'b1) begin errors++; $display("FAIL ov_err[%0d] got %b want 1", c, err_overflow); end
         @(negedge clk);
      end
      exp_msgs++;
      checks += 2;
      if (beat != 4) begin errors++; $display("FAIL ov_beats got %0d want 4", beat); end
      if (msg_count !== exp_msgs) begin errors++; $display("FAIL ov_msgs got %0d want %0d", msg_count, exp_msgs); end
      // A legal payload afterwards must not clear the sticky flag.
      offer(32'h0000005A, 3'd1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ov_next_valid got %b want 1", out_valid); end
      if (out_data !== 8'h5A) begin errors++; $display("FAIL ov_next_data got %h want 5a", out_data); end
      if (out_last !== 1'b1) begin errors++; $display("FAIL ov_next_last got %b want 1", out_last); end
      if (err_overflow !== 1'b1) begin errors++; $display("FAIL ov_sticky got %b want 1", err_overflow); end
      @(negedge clk);
      #1;
      exp_msgs++;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL ov_next_done got %b want 0", out_valid); end
      if (err_overflow !== 1'b1) begin errors++; $display("FAIL ov_sticky2 got %b want 1", err_overflow); end
      if (msg_count !== exp_msgs) begin errors++; $display("FAIL ov_next_msgs got %0d want %0d", msg_count, exp_msgs); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready = 1'b1;
      offer(32'h0D0C0B0A, 3'd4, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         #1;
         checks++;
         if (out_data !== 8'(8'h0A + b)) begin errors++; $display("FAIL rm_data[%0d] got %h want %h", b, out_data, 8'(8'h0A + b)); end
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      checks += 7;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL rm_data got %h want 00", out_data); end
      if (out_last !== 1'b0) begin errors++; $display("FAIL rm_last got %b want 0", out_last); end
      if (out_empty !== 1'b0) begin errors++; $display("FAIL rm_empty got %b want 0", out_empty); end
      if (msg_count !== 16'd0) begin errors++; $display("FAIL rm_msgs got %0d want 0", msg_count); end
      if (err_overflow !== 1'b0) begin errors++; $display("FAIL rm_err got %b want 0", err_overflow); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_msgs = '0;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks += 2;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_residual[%0d] got %b want 0", c, out_valid); end
         if (msg_count !== exp_msgs) begin errors++; $display("FAIL rm_msgs_after[%0d] got %0d want 0", c, msg_count); end
         @(negedge clk);
      end
   endtask

   initial begin
      clk             = 1'b0;
      rst_n           = 1'b0;
      in_valid        = 1'b0;
      in_data         = '0;
      in_num_elements = '0;
      in_eom          = 1'b0;
      out_ready       = 1'b0;
      checks          = 0;
      errors          = 0;
      exp_msgs        = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_zero_length();
      test_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
